// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: CPU byte FIFO in front of a shared UART transmitter,
// arbitrated round-robin against a secondary debug byte requester.
//
// Arbiter states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no byte offered to the emitter; pick a source, load tx_data
//   ST_SEND | tx_valid high, tx_data frozen until the emitter takes it
module uart_tx_arbiter #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_wr_valid,
    input  logic [7:0]                 cpu_wr_data,
    output logic                       cpu_busy,
    output logic [$clog2(DEPTH):0]     cpu_level,
    output logic [7:0]                 ovf_count,
    input  logic                       dbg_valid,
    input  logic [7:0]                 dbg_data,
    output logic                       dbg_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic            cur_src;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [LW-1:0]   level;
    logic [7:0]      ovf_cnt;
    logic [7:0]      tx_data_r;
    logic [7:0]      mem [DEPTH];

    logic            fifo_full;
    logic            fifo_nonempty;
    logic            grant_cpu;
    logic            grant_dbg;
    logic            xfer_done;
    logic            pop;
    logic            push;
    logic            drop;

    assign fifo_full     = (level == LW'(DEPTH));
    assign fifo_nonempty = (level != '0);

    // A pop frees a slot at the same edge, so a write into a full FIFO
    // is still accepted when IDLE is draining the head.
    assign pop  = grant_cpu;
    assign push = cpu_wr_valid && (!fifo_full || pop);
    assign drop = cpu_wr_valid && !push;

    assign cpu_busy  = fifo_full;
    assign cpu_level = level;
    assign ovf_count = ovf_cnt;
    assign tx_data   = tx_data_r;
    assign dbg_ready = grant_dbg;

    // Arbiter next-state, grant decode and emitter handshake.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        tx_valid  = 1'b0;
        xfer_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_nonempty && dbg_valid) begin
                    // Tie: the source that did not win the last transfer goes.
                    if (last_grant == SRC_DBG) begin
                        grant_cpu = 1'b1;
                    end else begin
                        grant_dbg = 1'b1;
                    end
                end else if (fifo_nonempty) begin
                    grant_cpu = 1'b1;
                end else if (dbg_valid) begin
                    grant_dbg = 1'b1;
                end
                if (grant_cpu || grant_dbg) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    xfer_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outgoing byte and its source are captured only on the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_r <= 8'h00;
            cur_src   <= SRC_DBG;
        end else if (grant_cpu) begin
            tx_data_r <= mem[rd_ptr];
            cur_src   <= SRC_CPU;
        end else if (grant_dbg) begin
            tx_data_r <= dbg_data;
            cur_src   <= SRC_DBG;
        end
    end

    // Round-robin memory; starts at debug so the CPU wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= SRC_DBG;
        end else if (xfer_done) begin
            last_grant <= cur_src;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_wr_data;
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter; push and pop together leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + LW'(1);
        end else if (pop && !push) begin
            level <= level - LW'(1);
        end
    end

    // Dropped-byte counter, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt <= 8'h00;
        end else if (drop && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'h01;
        end
    end

endmodule
